// File: rtl/hex_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hex_count_ctrl
// Description : Run/pause/step controller for a 4-bit hex display counter.
//               Edge-detects button levels, owns the count prescaler and
//               sequences the counter through IDLE/RUN/PAUSE.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_count_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int PRE_W    = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       up_dn,
    output logic [3:0] count,
    output logic       running,
    output logic       paused,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [PRE_W-1:0] c_tick_last = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] c_pre_one   = PRE_W'(1);

    state_t           r_state;
    logic [PRE_W-1:0] r_pre;
    logic [3:0]       r_count;
    logic             r_wrap;
    logic             r_running;
    logic             r_paused;
    logic             r_start_prev;
    logic             r_stop_prev;
    logic             r_step_prev;
    logic             r_load_prev;

    logic             w_start_e;
    logic             w_stop_e;
    logic             w_step_e;
    logic             w_load_e;
    logic             w_eff_stop;
    logic             w_eff_start;
    logic             w_counting;
    logic             w_advance;
    state_t           w_state_nxt;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [3:0]       w_count_nxt;
    logic             w_wrap_nxt;

    assign w_start_e = start & ~r_start_prev;
    assign w_stop_e  = stop  & ~r_stop_prev;
    assign w_step_e  = step  & ~r_step_prev;
    assign w_load_e  = load  & ~r_load_prev;

    // Stop in IDLE and start in RUN are no-ops, so they do not suppress lower
    // priority actions; a simultaneous stop always overrides start.
    assign w_eff_stop  = w_stop_e && (r_state != ST_IDLE);
    assign w_eff_start = w_start_e && !w_stop_e && (r_state != ST_RUN);

    // The prescaler runs in RUN and also in the cycle that resumes from PAUSE,
    // so a resumed run keeps the phase it had when it was paused.
    assign w_counting = (r_state == ST_RUN) || ((r_state == ST_PAUSE) && w_eff_start);

    // Next-state decode of the run/pause sequencer
    always_comb begin
        w_state_nxt = r_state;
        if (w_eff_stop) begin
            w_state_nxt = (r_state == ST_RUN) ? ST_PAUSE : ST_IDLE;
        end else if (w_eff_start) begin
            w_state_nxt = ST_RUN;
        end
    end

    // Prescaler/count update with load > stop > start > tick/step priority
    always_comb begin
        w_pre_nxt   = r_pre;
        w_count_nxt = r_count;
        w_advance   = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (w_load_e) begin
            w_count_nxt = load_val;
            w_pre_nxt   = '0;
        end else if (w_eff_stop) begin
            if (r_state == ST_PAUSE) begin
                w_count_nxt = 4'd0;
                w_pre_nxt   = '0;
            end
        end else if (w_eff_start && (r_state == ST_IDLE)) begin
            w_pre_nxt = '0;
        end else if (w_counting) begin
            if (r_pre == c_tick_last) begin
                w_pre_nxt = '0;
                w_advance = 1'b1;
            end else begin
                w_pre_nxt = r_pre + c_pre_one;
            end
        end else if (w_step_e) begin
            w_advance = 1'b1;
        end

        if (w_advance) begin
            if (up_dn) begin
                w_count_nxt = r_count + 4'd1;
                w_wrap_nxt  = (r_count == 4'hF);
            end else begin
                w_count_nxt = r_count - 4'd1;
                w_wrap_nxt  = (r_count == 4'h0);
            end
        end
    end

    // State, datapath and button history registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_pre        <= '0;
            r_count      <= 4'd0;
            r_wrap       <= 1'b0;
            r_running    <= 1'b0;
            r_paused     <= 1'b0;
            r_start_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
            r_step_prev  <= 1'b0;
            r_load_prev  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pre        <= w_pre_nxt;
            r_count      <= w_count_nxt;
            r_wrap       <= w_wrap_nxt;
            r_running    <= (w_state_nxt == ST_RUN);
            r_paused     <= (w_state_nxt == ST_PAUSE);
            r_start_prev <= start;
            r_stop_prev  <= stop;
            r_step_prev  <= step;
            r_load_prev  <= load;
        end
    end

    assign count   = r_count;
    assign running = r_running;
    assign paused  = r_paused;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_hex_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_count_ctrl
// Description : Self-checking bench for hex_count_ctrl with TICK_DIV=4.
//               Expected {count,running,paused,wrap} per cycle are queued on
//               drive and compared one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_count_ctrl;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stop;
    logic       step;
    logic       load;
    logic [3:0] load_val;
    logic       up_dn;
    logic [3:0] count;
    logic       running;
    logic       paused;
    logic       wrap;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [6:0] sb[$];

    hex_count_ctrl #(
        .TICK_DIV (4),
        .PRE_W    (8)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .up_dn    (up_dn),
        .count    (count),
        .running  (running),
        .paused   (paused),
        .wrap     (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            $display("FAIL %s: got count=%h run=%b pause=%b wrap=%b, expected count=%h run=%b pause=%b wrap=%b",
                     tag, obs[6:3], obs[2], obs[1], obs[0], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end else begin
            n_pass++;
        end
    endtask

    // Queue the expectation for the coming edge, clock once, then compare.
    task automatic cyc_exp(input string tag, input logic [3:0] c, input logic r,
                           input logic p, input logic w);
        logic [6:0] exp_v;
        sb.push_back({c, r, p, w});
        @(posedge clock);
        #1;
        exp_v = sb.pop_front();
        check_val(tag, {count, running, paused, wrap}, exp_v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        step     = 1'b0;
        load     = 1'b0;
        load_val = 4'h0;
        up_dn    = 1'b1;

        // Reset held with buttons toggling
        for (int i = 0; i < 3; i++) begin
            start    = (i % 2 == 0);
            stop     = (i % 2 == 1);
            step     = (i % 2 == 0);
            load     = 1'b1;
            load_val = 4'hF;
            cyc_exp("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        end
        start = 1'b0; stop = 1'b0; step = 1'b0; load = 1'b0;
        reset = 1'b1;
        cyc_exp("reset_release", 4'h0, 1'b0, 1'b0, 1'b0);

        // Start from IDLE, count up every 4 cycles
        start = 1'b1;
        cyc_exp("start", 4'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc_exp("run_up", 4'(k / 4), 1'b1, 1'b0, 1'b0);
        end

        // Load E while running, wrap up through 0, then wrap down to F
        load = 1'b1; load_val = 4'hE;
        cyc_exp("load_run", 4'hE, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            logic [3:0] ec;
            if (k < 4)       ec = 4'hE;
            else if (k < 8)  ec = 4'hF;
            else if (k < 12) ec = 4'h0;
            else             ec = 4'hF;
            cyc_exp("wrap_seq", ec, 1'b1, 1'b0, (k == 8) || (k == 12));
            if (k == 9) up_dn = 1'b0;
        end

        // Pause two cycles before a tick, resume, then clear with a second stop
        up_dn = 1'b1; load = 1'b1; load_val = 4'h5;
        cyc_exp("load5", 4'h5, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        cyc_exp("run5", 4'h5, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        cyc_exp("pause", 4'h5, 1'b0, 1'b1, 1'b0);
        stop = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc_exp("pause_hold", 4'h5, 1'b0, 1'b1, 1'b0);
        end
        start = 1'b1;
        cyc_exp("resume", 4'h5, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        cyc_exp("resume_wait", 4'h5, 1'b1, 1'b0, 1'b0);
        cyc_exp("resume_adv", 4'h6, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        cyc_exp("stop_a", 4'h6, 1'b0, 1'b1, 1'b0);
        stop = 1'b0;
        cyc_exp("stop_gap", 4'h6, 1'b0, 1'b1, 1'b0);
        stop = 1'b1;
        cyc_exp("stop_clear", 4'h0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;

        // Load and stop landing on a tick, then a held step
        start = 1'b1;
        cyc_exp("start2", 4'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc_exp("run0", 4'h0, 1'b1, 1'b0, 1'b0);
        end
        load = 1'b1; load_val = 4'h7; stop = 1'b1;
        cyc_exp("load_stop_tick", 4'h7, 1'b0, 1'b1, 1'b0);
        load = 1'b0; stop = 1'b0;
        step = 1'b1;
        cyc_exp("step_first", 4'h8, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 19; k++) begin
            cyc_exp("step_held", 4'h8, 1'b0, 1'b1, 1'b0);
        end
        step = 1'b0;

        // Reset in the middle of RUN at prescaler 2, count 9
        load = 1'b1; load_val = 4'h9;
        cyc_exp("load9", 4'h9, 1'b0, 1'b1, 1'b0);
        load = 1'b0; start = 1'b1;
        cyc_exp("resume9", 4'h9, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        cyc_exp("run9", 4'h9, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        cyc_exp("reset_mid", 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; start = 1'b1;
        cyc_exp("start3", 4'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc_exp("after_reset", 4'h0, 1'b1, 1'b0, 1'b0);
        end
        cyc_exp("first_adv", 4'h1, 1'b1, 1'b0, 1'b0);

        // Step down in PAUSE from 1 to 0, then 0 to F with wrap
        up_dn = 1'b0; stop = 1'b1;
        cyc_exp("pause3", 4'h1, 1'b0, 1'b1, 1'b0);
        stop = 1'b0; step = 1'b1;
        cyc_exp("step_down", 4'h0, 1'b0, 1'b1, 1'b0);
        step = 1'b0;
        cyc_exp("step_gap", 4'h0, 1'b0, 1'b1, 1'b0);
        step = 1'b1;
        cyc_exp("step_wrap", 4'hF, 1'b0, 1'b1, 1'b1);
        step = 1'b0;
        cyc_exp("step_wrap_end", 4'hF, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
